// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment decode,
// blank pattern and counter sizing helpers.
package seg7_pkg;

  // Active-high segment byte with every segment and the decimal point off.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Width of a counter that runs 0..terminal-1; never narrower than 1 bit.
  function automatic int cnt_width(input int terminal);
    return (terminal <= 1) ? 1 : $clog2(terminal);
  endfunction

  // Clocks per event for a given event rate; clamps to 1 when the rate
  // is at or above the clock frequency.
  function automatic int tick_div(input int clk_hz, input int rate_hz);
    int d;
    d = clk_hz / rate_hz;
    return (d < 1) ? 1 : d;
  endfunction

  // Hex nibble to active-high a..g pattern (bit 0 = a, bit 6 = g, bit 7 = dp off).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick for the one cycle
// in which the count wraps. DIV=1 gives a tick every cycle.
module tick_gen
  import seg7_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_in,
  output logic tick
);

  localparam int             W    = cnt_width(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: advance, or return to zero at the terminal value.
  always_comb begin
    // NOTE: every variable gets a value before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q + W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with double-buffered loads
// applied at frame boundaries, leading-zero blanking, per-digit blink,
// 16-step PWM brightness and a frame_done strobe.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int DIGITS     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int                TICK      = tick_div(CLK_FREQ, SCAN_HZ);
  localparam int                BLINK_DIV = tick_div(CLK_FREQ, 2 * BLINK_HZ);
  localparam int                SW        = cnt_width(DIGITS);
  localparam logic [SW-1:0]     LAST_SLOT = SW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic slot_tick;
  logic blink_tick;

  tick_gen #(.DIV(TICK)) u_slot_prescaler (
    .clk    (clk),
    .rst_in (rst_in),
    .tick   (slot_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_timer (
    .clk    (clk),
    .rst_in (rst_in),
    .tick   (blink_tick)
  );

  // State registers and their next values.
  logic [SW-1:0]         slot_q,       slot_d;
  logic [3:0]            pwm_q,        pwm_d;
  logic                  blink_on_q,   blink_on_d;
  logic [4*DIGITS-1:0]   pend_val_q,   pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q,    pend_dp_d;
  logic [DIGITS-1:0]     pend_blink_q, pend_blink_d;
  logic                  pend_flag_q,  pend_flag_d;
  logic [4*DIGITS-1:0]   disp_val_q,   disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q,    disp_dp_d;
  logic [DIGITS-1:0]     disp_blink_q, disp_blink_d;
  logic [7:0]            seg_q,        seg_d;
  logic [DIGITS-1:0]     an_q,         an_d;
  logic                  frame_done_q, frame_done_d;

  // Per-slot view of the display buffer.
  logic                  frame_wrap;
  logic [3:0]            nib;
  logic                  lz_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  logic [DIGITS-1:0]     an_hot;
  logic                  dark;
  logic [7:0]            seg_hi;
  logic [DIGITS-1:0]     an_hi;

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

  // Slot sequencing, free-running PWM/blink, and the double buffer swap.
  always_comb begin
    frame_wrap   = slot_tick && (slot_q == LAST_SLOT);
    slot_d       = slot_q;
    pwm_d        = pwm_q + 4'd1;
    blink_on_d   = blink_tick ? ~blink_on_q : blink_on_q;
    frame_done_d = frame_wrap;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_flag_d  = pend_flag_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    disp_blink_d = disp_blink_q;

    if (slot_tick) slot_d = frame_wrap ? '0 : slot_q + SW'(1);

    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_blink_d = blink_mask;
      pend_flag_d  = 1'b1;
    end

    // Display data only ever changes here, so a frame never mixes two loads.
    // A load in the boundary cycle itself is newer than any pending data.
    if (frame_wrap) begin
      if (load) begin
        disp_val_d   = value;
        disp_dp_d    = dp_in;
        disp_blink_d = blink_mask;
        pend_flag_d  = 1'b0;
      end else if (pend_flag_q) begin
        disp_val_d   = pend_val_q;
        disp_dp_d    = pend_dp_q;
        disp_blink_d = pend_blink_q;
        pend_flag_d  = 1'b0;
      end
    end
  end

  // Select the current slot's digit and work out leading-zero blanking,
  // scanning from the most significant digit down.
  always_comb begin
    nib       = 4'h0;
    lz_run    = blank_lz;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_hot    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_val_q[4*i +: 4];
      if ((nib != 4'h0) || (i == 0)) lz_run = 1'b0;
      if (slot_q == SW'(i)) begin
        cur_nib   = nib;
        cur_dp    = disp_dp_q[i];
        cur_blink = disp_blink_q[i];
        cur_lz    = lz_run;
        an_hot[i] = 1'b1;
      end
    end
  end

  // Output pattern: dark slots drive nothing; a blanked digit keeps its dp;
  // PWM gates only the anode.
  always_comb begin
    dark   = (cur_blink && !blink_on_q) || (cur_lz && !cur_dp);
    seg_hi = SEG_BLANK;
    an_hi  = '0;
    if (!dark) begin
      seg_hi    = cur_lz ? SEG_BLANK : hex_to_seg(cur_nib);
      seg_hi[7] = cur_dp;
      if (pwm_q <= brightness) an_hi = an_hot;
    end
    seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_d  = (ACTIVE_LOW != 0) ? ~an_hi  : an_hi;
  end

  // All state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      slot_q       <= '0;
      pwm_q        <= 4'd0;
      blink_on_q   <= 1'b1;
      // NOTE: the buffers are reset so the display comes up on a defined
      // all-zero frame; storage without such a need would stay unreset.
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      pwm_q        <= pwm_d;
      blink_on_q   <= blink_on_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blink_q <= disp_blink_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at CLK_FREQ=64, SCAN_HZ=16 (4 clks/slot),
// BLINK_HZ=2 (16-clk half-period), DIGITS=4, active-low outputs.
// Expected frames go into a queue; a monitor pops one at each frame_done
// and compares the following frame slot by slot.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] an4;   // slot k anode pattern in bits [4k+3:4k]
    logic [31:0] seg4;  // slot k segment byte in bits [8k+7:8k]
  } frame_t;

  frame_t exp_q[$];
  logic   mon_busy = 1'b0;

  seg7_scan_driver #(
    .CLK_FREQ  (64),
    .SCAN_HZ   (16),
    .BLINK_HZ  (2),
    .DIGITS    (4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .value      (value),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input string name, input logic [15:0] an4, input logic [31:0] seg4);
    frame_t e;
    e.name = name;
    e.an4  = an4;
    e.seg4 = seg4;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge where frame_done is seen high.
  task automatic wait_fd(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 64);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_done not seen within 64 clocks", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mon_busy) begin
      checks++;
      errors++;
      $display("FAIL %s: expected frame not observed within 200 clocks", name);
    end
  endtask

  // Two clocks into a frame, well clear of the next boundary.
  task automatic sync_mid(input string name);
    wait_fd(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] mask);
    value      = v;
    dp_in      = dp;
    blink_mask = mask;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic frame_case(input string name, input logic [15:0] v, input logic [3:0] dp,
                            input logic [15:0] an4, input logic [31:0] seg4);
    sync_mid(name);
    do_load(v, dp, 4'h0);
    push_frame(name, an4, seg4);
    wait_idle(name);
  endtask

  // Monitor: at each frame_done with an expectation queued, sample each
  // slot of the new frame mid-slot (negedges 2, 6, 10, 14 after the pulse).
  initial begin : monitor
    frame_t e;
    forever begin
      @(negedge clk);
      if (frame_done && exp_q.size() != 0) begin
        mon_busy = 1'b1;
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          repeat ((k == 0) ? 2 : 4) @(negedge clk);
          check($sformatf("%s an[%0d]", e.name, k), 32'(an), 32'(e.an4[4*k +: 4]));
          check($sformatf("%s seg[%0d]", e.name, k), 32'(seg), 32'(e.seg4[8*k +: 8]));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int          n;
    int          on_cnt;
    int          multi;
    logic [11:0] d0;
    logic [11:0] prev_d0;

    // 1 Reset
    repeat (3) @(negedge clk);
    check("rst seg", 32'(seg), 32'h0000_00FF);
    check("rst an", 32'(an), 32'h0000_000F);
    check("rst frame_done", 32'(frame_done), 32'h0);
    push_frame("rst_buffers", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    rst_in = 1'b1;
    wait_idle("rst_buffers");

    // 2 Scan order and decode
    frame_case("scan", 16'h12AF, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'h88, 8'h8E});
    wait_fd("period");
    @(negedge clk);
    check("frame_done width", 32'(frame_done), 32'h0);
    n = 1;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame period", 32'(n), 32'd16);
    @(negedge clk);
    n = 0;
    while (an == 4'hE && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("slot length", 32'(n), 32'd4);
    check("slot after 0", 32'(an), 32'h0000_000D);

    // 3 Leading-zero blanking
    blank_lz = 1'b1;
    frame_case("lz_0005", 16'h0005, 4'h0, {4'hF, 4'hF, 4'hF, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'h92});
    frame_case("lz_0000", 16'h0000, 4'h0, {4'hF, 4'hF, 4'hF, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
    frame_case("lz_dp2", 16'h0000, 4'b0100, {4'hF, 4'hB, 4'hF, 4'hE}, {8'hFF, 8'h7F, 8'hFF, 8'hC0});
    frame_case("lz_0305", 16'h0305, 4'h0, {4'hF, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hB0, 8'hC0, 8'h92});
    blank_lz = 1'b0;

    // 4 Double buffer: last load in a frame wins
    sync_mid("dbuf");
    do_load(16'h1111, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'h0);
    push_frame("dbuf_last_wins", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hA4, 8'hA4, 8'hA4, 8'hA4});
    wait_idle("dbuf_last_wins");

    // Load in the boundary cycle (15 clocks after a frame_done) applies at once
    wait_fd("bnd");
    repeat (15) @(negedge clk);
    value      = 16'h3C3C;
    dp_in      = 4'h0;
    blink_mask = 4'h0;
    load       = 1'b1;
    push_frame("bnd_load", {4'h7, 4'hB, 4'hD, 4'hE}, {8'hB0, 8'hC6, 8'hB0, 8'hC6});
    @(negedge clk);
    load = 1'b0;
    check("bnd frame_done", 32'(frame_done), 32'h1);
    wait_idle("bnd_load");

    // 5 PWM: total anode-on time over 64 clocks
    brightness = 4'd3;
    on_cnt = 0;
    multi  = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an != 4'hF) on_cnt++;
      if (!(an inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) multi++;
    end
    check("pwm3 on clocks", 32'(on_cnt), 32'd16);
    check("pwm3 one-hot", 32'(multi), 32'd0);
    brightness = 4'd15;
    @(negedge clk);
    on_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an != 4'hF) on_cnt++;
    end
    check("pwm15 on clocks", 32'(on_cnt), 32'd64);

    // 6 Blink digit 0: dark in alternating 16-clock frames; digit 1 steady
    sync_mid("blink");
    do_load(16'h8888, 4'h0, 4'b0001);
    wait_fd("blink_apply");
    prev_d0 = 12'h0;
    for (int f = 0; f < 4; f++) begin
      repeat (2) @(negedge clk);
      d0 = {an, seg};
      if (f == 0)
        check("blink d0 legal", 32'((d0 == {4'hE, 8'h80}) || (d0 == {4'hF, 8'hFF})), 32'h1);
      else
        check($sformatf("blink d0 f%0d", f), 32'(d0),
              32'((prev_d0 == {4'hE, 8'h80}) ? {4'hF, 8'hFF} : {4'hE, 8'h80}));
      prev_d0 = d0;
      repeat (4) @(negedge clk);
      check($sformatf("blink d1 f%0d", f), 32'({an, seg}), 32'({4'hD, 8'h80}));
      wait_fd("blink_next");
    end

    // 1b Reset mid-frame
    sync_mid("midrst");
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    check("midrst seg", 32'(seg), 32'h0000_00FF);
    check("midrst an", 32'(an), 32'h0000_000F);
    check("midrst frame_done", 32'(frame_done), 32'h0);
    rst_in = 1'b1;
    n = 0;
    while (!frame_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("midrst first frame", 32'(n), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
